ff_pipe: RTL and testbench

//   Parametrised elastic register pipeline: DEPTH stages of DATA_WIDTH-bit registers,

---
 rtl/ff_pipe.sv | 123 ++++++++++++
 tb/tb_ff_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ff_pipe
// Brief    : Elastic valid/ready register pipeline of DEPTH stages with
//            bubble collapse, flush and occupancy tracking. Optional output
//            stall counter enabled by macro FF_PIPE_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ff_pipe #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RI,
    input  logic                       Flush_SI,
    input  logic                       InValid_SI,
    output logic                       InReady_SO,
    input  logic [DATA_WIDTH-1:0]      D_DI,
    output logic                       OutValid_SO,
    input  logic                       OutReady_SI,
    output logic [DATA_WIDTH-1:0]      Q_DO,
    output logic [$clog2(DEPTH+1)-1:0] Occupancy_DO,
    output logic [CNT_WIDTH-1:0]       StallCnt_DO
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]                 v_q, v_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] d_q, d_d;
    logic [OCC_W-1:0]                 occ_q, occ_d;

    logic [DEPTH-1:0]                 w_rdy;
    logic [DEPTH-1:0]                 w_src_v;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] w_src_d;
    logic                             w_in_xfer;
    logic                             w_out_xfer;

    // A stage can load when it is empty or the stage after it is moving.
    always_comb begin : p_ready
        logic r_chain;
        w_rdy          = '0;
        r_chain        = OutReady_SI | ~v_q[DEPTH-1];
        w_rdy[DEPTH-1] = r_chain;
        for (int k = DEPTH-2; k >= 0; k--) begin
            r_chain  = ~v_q[k] | r_chain;
            w_rdy[k] = r_chain;
        end
    end

    assign w_src_v[0] = InValid_SI;
    assign w_src_d[0] = D_DI;

    generate
        for (genvar k = 1; k < DEPTH; k++) begin : g_src
            assign w_src_v[k] = v_q[k-1];
            assign w_src_d[k] = d_q[k-1];
        end
    endgenerate

    assign InReady_SO = w_rdy[0] & ~Flush_SI;
    assign w_in_xfer  = InValid_SI & InReady_SO;
    assign w_out_xfer = v_q[DEPTH-1] & OutReady_SI;

    // Bubbles clear the valid bit but keep the old data to avoid needless toggling.
    always_comb begin : p_next
        v_d = v_q;
        d_d = d_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (Flush_SI) begin
                v_d[k] = 1'b0;
            end else if (w_rdy[k]) begin
                v_d[k] = w_src_v[k];
                if (w_src_v[k]) begin
                    d_d[k] = w_src_d[k];
                end
            end
        end
    end

    always_comb begin : p_occ
        if (Flush_SI) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            v_q   <= '0;
            d_q   <= '0;
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

    assign OutValid_SO  = v_q[DEPTH-1];
    assign Q_DO         = d_q[DEPTH-1];
    assign Occupancy_DO = occ_q;

`ifdef FF_PIPE_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q;

    // Saturating count of cycles where the output word waited on downstream.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            stall_q <= '0;
        end else if (v_q[DEPTH-1] && !OutReady_SI && !(&stall_q)) begin
            stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end

    assign StallCnt_DO = stall_q;
`else
    assign StallCnt_DO = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ff_pipe
// Brief    : Directed self-checking bench for ff_pipe (DEPTH=3 and DEPTH=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ff_pipe;

`ifdef FF_PIPE_STALL_CNT_EN
    localparam int STALL_EN = 1;
`else
    localparam int STALL_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [5:0] d;
    logic       in_ready, out_valid;
    logic [5:0] q;
    logic [1:0] occ;
    logic [1:0] stall;

    logic        flush1, in_valid1, out_ready1;
    logic [5:0]  d1;
    logic        in_ready1, out_valid1;
    logic [5:0]  q1;
    logic [0:0]  occ1;
    logic [15:0] stall1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ff_pipe #(.DATA_WIDTH(6), .DEPTH(3), .CNT_WIDTH(2)) u_dut (
        .Clk_CI(clk), .Rst_RI(rst), .Flush_SI(flush),
        .InValid_SI(in_valid), .InReady_SO(in_ready), .D_DI(d),
        .OutValid_SO(out_valid), .OutReady_SI(out_ready), .Q_DO(q),
        .Occupancy_DO(occ), .StallCnt_DO(stall)
    );

    ff_pipe #(.DATA_WIDTH(6), .DEPTH(1), .CNT_WIDTH(16)) u_dut1 (
        .Clk_CI(clk), .Rst_RI(rst), .Flush_SI(flush1),
        .InValid_SI(in_valid1), .InReady_SO(in_ready1), .D_DI(d1),
        .OutValid_SO(out_valid1), .OutReady_SI(out_ready1), .Q_DO(q1),
        .Occupancy_DO(occ1), .StallCnt_DO(stall1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int v, input int dq, input int o);
        chk({tag, ".valid"}, 32'(out_valid), v);
        chk({tag, ".q"},     32'(q),         dq);
        chk({tag, ".occ"},   32'(occ),       o);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; d1 = '0;
        tick(); tick();
        chk_out("rst", 0, 0, 0);
        chk("rst.stall",  32'(stall),     0);
        chk("rst.inrdy",  32'(in_ready),  1);
        chk("rst1.valid", 32'(out_valid1), 0);
        chk("rst1.occ",   32'(occ1),      0);
        chk("rst1.inrdy", 32'(in_ready1), 1);
        rst = 1'b0;

        // Streaming, no back-pressure
        out_ready = 1'b1; in_valid = 1'b1; d = 6'd1;
        tick();
        chk_out("t1.e1", 0, 0, 1);
        d = 6'd2; tick();
        d = 6'd3; tick();
        chk_out("t1.e3", 1, 1, 3);
        d = 6'd4; tick();
        chk_out("t1.e4", 1, 2, 3);
        in_valid = 1'b0; tick();
        chk_out("t1.e5", 1, 3, 2);
        tick();
        chk_out("t1.e6", 1, 4, 1);
        tick();
        chk_out("t1.e7", 0, 4, 0);

        // Fill then stall, then simultaneous in/out while full
        out_ready = 1'b0; in_valid = 1'b1; d = 6'h0A; tick();
        d = 6'h0B; tick();
        d = 6'h0C; tick();
        d = 6'h0D; #1;
        chk("t2.full_inrdy", 32'(in_ready), 0);
        chk_out("t2.full", 1, 32'h0A, 3);
        tick();
        chk_out("t2.hold", 1, 32'h0A, 3);
        out_ready = 1'b1; #1;
        chk("t2.rel_inrdy", 32'(in_ready), 1);
        tick();
        chk_out("t2.xfer", 1, 32'h0B, 3);
        in_valid = 1'b0; tick();
        chk_out("t2.d1", 1, 32'h0C, 2);
        tick();
        chk_out("t2.d2", 1, 32'h0D, 1);
        tick();
        chk_out("t2.d3", 0, 32'h0D, 0);

        // Bubble collapse under stall
        out_ready = 1'b0; in_valid = 1'b1; d = 6'h11; tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; d = 6'h12; tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk_out("t3.stall", 1, 32'h11, 2);
        chk("t3.inrdy", 32'(in_ready), 1);
        out_ready = 1'b1; tick();
        chk_out("t3.r1", 1, 32'h12, 1);
        tick();
        chk_out("t3.r2", 0, 32'h12, 0);

        // Flush with a word offered
        out_ready = 1'b0; in_valid = 1'b1; d = 6'h21; tick();
        d = 6'h22; tick();
        chk("t4.occ", 32'(occ), 2);
        flush = 1'b1; d = 6'h3F; #1;
        chk("t4.inrdy", 32'(in_ready), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk_out("t4.flushed", 0, 32'h12, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("t4.after", 0, 32'h12, 0);
        end

        // Reset mid-stall
        out_ready = 1'b0; in_valid = 1'b1; d = 6'h31; tick();
        d = 6'h32; tick();
        d = 6'h33; tick();
        in_valid = 1'b0; tick();
        chk_out("t5.pre", 1, 32'h31, 3);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk_out("t5.rst", 0, 0, 0);
        chk("t5.stall", 32'(stall), 0);
        in_valid = 1'b1; d = 6'h05; out_ready = 1'b1; tick();
        in_valid = 1'b0; tick();
        chk("t5.lat2", 32'(out_valid), 0);
        tick();
        chk_out("t5.lat3", 1, 5, 1);
        tick();
        chk_out("t5.drain", 0, 5, 0);

        // Stall counter saturation; flush does not clear it
        out_ready = 1'b0; in_valid = 1'b1; d = 6'h06; tick();
        in_valid = 1'b0; tick(); tick();
        chk_out("t6.arrive", 1, 6, 1);
        chk("t6.stall0", 32'(stall), 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("t6.stall", 32'(stall), STALL_EN * ((i > 3) ? 3 : i));
        end
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("t6.flush_stall", 32'(stall), STALL_EN * 3);
        chk("t6.flush_valid", 32'(out_valid), 0);

        // DEPTH=1 instance
        in_valid1 = 1'b1; d1 = 6'h01; out_ready1 = 1'b0; tick();
        chk("d1.valid", 32'(out_valid1), 1);
        chk("d1.q",     32'(q1),         1);
        chk("d1.occ",   32'(occ1),       1);
        d1 = 6'h02; #1;
        chk("d1.full_inrdy", 32'(in_ready1), 0);
        tick();
        chk("d1.hold_q", 32'(q1), 1);
        out_ready1 = 1'b1; #1;
        chk("d1.rel_inrdy", 32'(in_ready1), 1);
        tick();
        chk("d1.x1_q",   32'(q1),   2);
        chk("d1.x1_occ", 32'(occ1), 1);
        d1 = 6'h03; tick();
        chk("d1.x2_q", 32'(q1), 3);
        in_valid1 = 1'b0; tick();
        chk("d1.empty_valid", 32'(out_valid1), 0);
        chk("d1.empty_occ",   32'(occ1),       0);
        chk("d1.stall",       32'(stall1),     STALL_EN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
